mem_core: RTL and testbench
===========================

// Module: mem_core
// PURPOSE
// - Single-port synchronous 32x8 memory array; the device under test driven
//   through the memInt.mem modport by the memory test bench.
// - Consumes read/write/addr/data_in strobes and returns registered data_out.
// - Built-in clear sequencer zeroes the whole array after reset.
// - Flags illegal simultaneous read+write requests.
// PARAMETERS
// - ADDR_WIDTH      5  address bits; depth = 2**ADDR_WIDTH
// - DATA_WIDTH      8  data bits per word
// - CLEAR_ON_RESET  1  1: run clear sequence after reset; 0: go straight to IDLE
// PORTS
// - clk         in   1           system clock, all logic on posedge
// - rst_n       in   1           reset, asynchronous, active-low
// - read        in   1           read request, sampled at posedge
// - write       in   1           write request, sampled at posedge
// - addr        in   ADDR_WIDTH  word address for read or write
// - data_in     in   DATA_WIDTH  write data
// - data_out    out  DATA_WIDTH  registered read data
// - busy        out  1           1 while clear sequence runs; requests ignored
// - rw_err      out  1           1-cycle pulse: read and write asserted together
// - parity_err  out  1           registered parity mismatch on last read
// BEHAVIOUR
// - One clock (clk). Reset rst_n is asynchronous, active-low.
// - Reset values: data_out=0, rw_err=0, parity_err=0, clr_cnt=0,
//   busy=CLEAR_ON_RESET, state=CLEAR if CLEAR_ON_RESET else IDLE.
// - Array contents are not touched by reset itself; only CLEAR zeroes them.
// - FSM states: CLEAR, IDLE.
//   - CLEAR: each cycle mem[clr_cnt] <= 0 and clr_cnt++. On clr_cnt==2**AW-1,
//     write last word then go to IDLE; busy drops the same edge. This takes
//     exactly 2**ADDR_WIDTH cycles (32 at default). read/write ignored, no
//     rw_err, data_out holds.
//   - IDLE: serve requests. Never returns to CLEAR except via rst_n.
// - Write (write=1, read=0): mem[addr] <= data_in at posedge; data_out unchanged.
// - Read (read=1, write=0): data_out <= mem[addr] at posedge. Latency is 1 cycle.
//   data_out holds until the next read.
// - Write then read of the same addr on the next cycle returns the new data.
// - read=1 and write=1 together: read is performed, write is dropped, and
//   rw_err=1 for exactly the following cycle.
// - Neither strobe: no state change; rw_err=0.
// - addr is ADDR_WIDTH wide, so all values are legal; no wrap or overflow case.
// - clr_cnt wraps to 0 only via reset.
// - Reset mid-CLEAR or mid-access: outputs take reset values immediately and
//   the FSM restarts CLEAR at clr_cnt=0. A write in the reset cycle is lost.
// CONFIGURATION
// - Macro MEM_PARITY_EN.
//   - Defined: each word stores an extra even-parity bit (^data_in), written
//     on write and as 0 during CLEAR. On read, parity_err <= stored parity
//     != ^word; it updates on every read and holds otherwise.
//   - Undefined: no parity storage; parity_err is tied to 0; the port is
//     kept so the interface is identical.
// TESTING
// - Reset release, CLEAR_ON_RESET=1 -> busy=1 for 32 cycles then 0; reads
//   of addr 0..31 return 8'h00.
// - Write addr=i data=i for i=0..31, then read each -> data_out==i one cycle
//   after each read strobe; rw_err stays 0.
// - Cycle 1 write addr 5 data 8'hA5, cycle 2 read addr 5 -> data_out=8'hA5
//   after cycle-2 edge.
// - read=1, write=1, addr 3, data 8'hFF with mem[3]=8'h03 -> data_out=8'h03,
//   mem[3] unchanged, rw_err high for 1 cycle.
// - Write during busy (addr 7 data 8'h55) -> ignored; read after CLEAR
//   returns 8'h00.
// - Assert rst_n low at CLEAR cycle 10 -> data_out=0 and busy=1 asynchronously;
//   after release, full 32-cycle CLEAR. With MEM_PARITY_EN, force a parity bit
//   flip on addr 2, read -> parity_err=1.

Source files
------------

// File: rtl/mem_core.sv
// ----------------------------------------------------------------------------
// mem_core
// Single-port synchronous memory array (2**ADDR_WIDTH words of DATA_WIDTH bits)
// with a built-in clear sequencer that zeroes the whole array after reset and
// a flag for illegal simultaneous read+write requests.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   rst_n       in   asynchronous active-low reset
//   read        in   read request, sampled at posedge
//   write       in   write request, sampled at posedge
//   addr        in   word address for read or write
//   data_in     in   write data
//   data_out    out  registered read data (1-cycle latency, holds between reads)
//   busy        out  high while the clear sequence runs; requests are ignored
//   rw_err      out  1-cycle pulse after a cycle with read and write together
//   parity_err  out  registered parity mismatch on the last read
//
// Optional feature (macro MEM_PARITY_EN):
//   Defined   : each word carries an even-parity bit checked on every read.
//   Undefined : no parity storage, parity_err is tied low.
// ----------------------------------------------------------------------------
module mem_core #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  rw_err,
    output logic                  parity_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;

    logic                    clr_we;
    logic                    rd_en;
    logic                    wr_en;
    logic                    conflict;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    // State register. Reset always lands in the configured start state, so a
    // reset in the middle of a clear restarts the whole sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and request decode. In CLEAR the user strobes are masked
    // entirely; in IDLE a simultaneous read+write keeps the read and drops
    // the write.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        clr_we     = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        conflict   = 1'b0;
        case (state)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                rd_en    = read;
                wr_en    = write & ~read;
                conflict = read & write;
            end
            default: begin
                next_state = RESET_STATE;
            end
        endcase
    end

    // Clear address counter. It stops on the last word rather than wrapping;
    // only reset brings it back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (clr_we && (clr_cnt != LAST_ADDR)) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Storage array. Not reset: contents only change through the clear
    // sequence or an accepted write.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            mem[addr] <= data_in;
        end
    end

    // Read data register and the conflict pulse. data_out only moves on an
    // accepted read, so it holds through writes, idle cycles and CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            rw_err   <= 1'b0;
        end else begin
            rw_err <= conflict;
            if (rd_en) begin
                data_out <= mem[addr];
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic par_mem [0:DEPTH-1];

    // Parity side-array, written in lockstep with the data array. Cleared
    // words get parity 0, which matches the even parity of an all-zero word.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_cnt] <= 1'b0;
        end else if (wr_en) begin
            par_mem[addr] <= ^data_in;
        end
    end

    // Parity check result, refreshed on every accepted read and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (rd_en) begin
            parity_err <= par_mem[addr] ^ (^mem[addr]);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_core.sv
// ----------------------------------------------------------------------------
// tb_mem_core
// Directed self-checking bench for mem_core at default parameters
// (32 x 8, clear on reset). Inputs change and outputs are sampled on the
// falling clock edge, half a cycle away from the active rising edge.
// ----------------------------------------------------------------------------
module tb_mem_core;

    logic       clk;
    logic       rst_n;
    logic       read;
    logic       write;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       busy;
    logic       rw_err;
    logic       parity_err;

    int errors;
    int checks;

    mem_core #(
        .ADDR_WIDTH     (5),
        .DATA_WIDTH     (8),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .busy       (busy),
        .rw_err     (rw_err),
        .parity_err (parity_err)
    );

    // Free-running clock, 10 time-unit period, rising edges at 5, 15, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one request, let exactly one rising edge consume it, and return
    // on the following falling edge so outputs can be sampled.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [4:0] a, input logic [7:0] d);
        read    = rd;
        write   = wr;
        addr    = a;
        data_in = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single comparison point: counts the check and reports any failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence.
    initial begin
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        data_in = '0;

        // Reset values while rst_n is held low.
        #2;
        checkOutput("reset_busy", 32'(busy), 32'd1);
        checkOutput("reset_data_out", 32'(data_out), 32'd0);
        checkOutput("reset_rw_err", 32'(rw_err), 32'd0);
        checkOutput("reset_parity_err", 32'(parity_err), 32'd0);

        // Release reset on a falling edge; the next 32 rising edges are CLEAR.
        // A write to addr 7 is held the whole time and must be ignored.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 31; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd7, 8'h55);
        end
        checkOutput("clear_busy_cycle31", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1, 5'd7, 8'h55);
        checkOutput("clear_busy_cycle32", 32'(busy), 32'd0);
        checkOutput("clear_data_out_hold", 32'(data_out), 32'd0);
        checkOutput("clear_rw_err", 32'(rw_err), 32'd0);

        // Every word reads back zero after CLEAR, including the masked write.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b0, 5'(i), 8'h00);
            checkOutput($sformatf("cleared_rd_%0d", i), 32'(data_out), 32'd0);
        end

        // Write addr=i data=i, then read each back one cycle after the strobe.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 5'(i), 8'(i));
        end
        checkOutput("write_data_out_hold", 32'(data_out), 32'd0);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b0, 5'(i), 8'h00);
            checkOutput($sformatf("pattern_rd_%0d", i), 32'(data_out), 32'(i));
            checkOutput($sformatf("pattern_rw_err_%0d", i), 32'(rw_err), 32'd0);
        end

        // Write followed immediately by a read of the same address.
        applyStimulus(1'b0, 1'b1, 5'd5, 8'hA5);
        checkOutput("wr5_data_out_hold", 32'(data_out), 32'd31);
        applyStimulus(1'b1, 1'b0, 5'd5, 8'h00);
        checkOutput("wr_then_rd_5", 32'(data_out), 32'hA5);

        // Read and write together: read wins, write dropped, 1-cycle rw_err.
        applyStimulus(1'b1, 1'b1, 5'd3, 8'hFF);
        checkOutput("conflict_data_out", 32'(data_out), 32'h03);
        checkOutput("conflict_rw_err_high", 32'(rw_err), 32'd1);
        applyStimulus(1'b0, 1'b0, 5'd3, 8'h00);
        checkOutput("conflict_rw_err_low", 32'(rw_err), 32'd0);
        checkOutput("idle_data_out_hold", 32'(data_out), 32'h03);
        applyStimulus(1'b1, 1'b0, 5'd5, 8'h00);
        checkOutput("rd5_after_conflict", 32'(data_out), 32'hA5);
        applyStimulus(1'b1, 1'b0, 5'd3, 8'h00);
        checkOutput("mem3_unchanged", 32'(data_out), 32'h03);
        checkOutput("idle_parity_err", 32'(parity_err), 32'd0);

        // Asynchronous reset from IDLE: outputs respond before any clock edge.
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_data_out", 32'(data_out), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd1);

        // Release, run 10 CLEAR cycles, then reset again mid-CLEAR. The
        // sequence must restart and take a full 32 cycles.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midclear_rst_busy", 32'(busy), 32'd1);
        checkOutput("midclear_rst_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 31; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        end
        checkOutput("restart_busy_cycle31", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        checkOutput("restart_busy_cycle32", 32'(busy), 32'd0);

        // Words written earlier are zero again after the restarted clear.
        applyStimulus(1'b1, 1'b0, 5'd31, 8'h00);
        checkOutput("recleared_rd_31", 32'(data_out), 32'd0);
        applyStimulus(1'b0, 1'b1, 5'd9, 8'h3C);
        applyStimulus(1'b1, 1'b0, 5'd9, 8'h00);
        checkOutput("post_restart_wr_rd_9", 32'(data_out), 32'h3C);
        applyStimulus(1'b1, 1'b0, 5'd5, 8'h00);
        checkOutput("recleared_rd_5", 32'(data_out), 32'd0);

`ifdef MEM_PARITY_EN
        // Corrupt the stored parity of addr 2 and confirm the read flags it;
        // a clean word read afterwards clears the flag.
        applyStimulus(1'b0, 1'b1, 5'd2, 8'h12);
        applyStimulus(1'b1, 1'b0, 5'd2, 8'h00);
        checkOutput("parity_clean_rd_2", 32'(parity_err), 32'd0);
        dut.par_mem[2] = ~dut.par_mem[2];
        applyStimulus(1'b1, 1'b0, 5'd2, 8'h00);
        checkOutput("parity_flip_data", 32'(data_out), 32'h12);
        checkOutput("parity_flip_err", 32'(parity_err), 32'd1);
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        checkOutput("parity_err_hold", 32'(parity_err), 32'd1);
        applyStimulus(1'b1, 1'b0, 5'd9, 8'h00);
        checkOutput("parity_recover_rd_9", 32'(parity_err), 32'd0);
`else
        checkOutput("parity_tied_low", 32'(parity_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
